// File: rtl/ff256_ct_seq_ctrl_acc_pkg.sv
// Shared definitions for the ff256_ct_seq family: lane geometry, FSM state
// encoding and the GF(256) addition helper used by the lane accumulators.
package ff256_ct_seq_ctrl_acc_pkg;

  localparam int N_LANES = 8;
  localparam int SYM_W   = 8;
  localparam int SEL_W   = 3;
  localparam int VEC_W   = N_LANES * SYM_W;

  localparam logic [SEL_W-1:0] STEP_ZERO = 3'd0;
  localparam logic [SEL_W-1:0] STEP_ONE  = 3'd1;
  localparam logic [SEL_W-1:0] STEP_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // GF(256) addition is a carry-free bitwise XOR; width never grows.
  function automatic logic [SYM_W-1:0] gf_add(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/ff256_ct_seq_ctrl_acc_if.sv
// Bus bundle between the sequencer/accumulator and its environment:
// input vector handshake, mux/multiplier side-channel and result handshake.
interface ff256_ct_seq_ctrl_acc_if;
  import ff256_ct_seq_ctrl_acc_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [VEC_W-1:0]     x_in;
  logic [VEC_W-1:0]     x_hold;
  logic [SEL_W-1:0]     selector [0:N_LANES-1];
  logic [SEL_W-1:0]     step;
  logic [SYM_W-1:0]     prod     [0:N_LANES-1];
  logic                 out_valid;
  logic                 out_ready;
  logic [VEC_W-1:0]     y_out;
  logic                 busy;

  modport slave (
    input  in_valid, x_in, prod, out_ready,
    output in_ready, x_hold, selector, step, out_valid, y_out, busy
  );

  modport master (
    output in_valid, x_in, prod, out_ready,
    input  in_ready, x_hold, selector, step, out_valid, y_out, busy
  );

endinterface

// File: rtl/ff256_ct_seq_xor_acc.sv
// Eight GF(256) lane accumulators. load_en restarts every lane with the
// current product (first step of a transform); acc_en folds the product in.
module ff256_ct_seq_xor_acc
  import ff256_ct_seq_ctrl_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             acc_en,
  input  logic [SYM_W-1:0] prod [0:N_LANES-1],
  output logic [SYM_W-1:0] acc  [0:N_LANES-1]
);

  logic [SYM_W-1:0] acc_r [0:N_LANES-1];

  // Lane accumulator registers: load has priority over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LANES; i++) acc_r[i] <= {SYM_W{1'b0}};
    end else if (load_en) begin
      for (int i = 0; i < N_LANES; i++) acc_r[i] <= prod[i];
    end else if (acc_en) begin
      for (int i = 0; i < N_LANES; i++) acc_r[i] <= gf_add(acc_r[i], prod[i]);
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/ff256_ct_seq_ctrl_acc.sv
// Sequencer + XOR accumulator for the sequential GF(256) cosine transform.
// Takes one 64-bit vector, walks 8 steps driving the lane selectors, folds
// the returned products into the lane accumulators and offers the result.
// Optional feature macro: FF256_CT_SEQ_DBUF_EN (one-deep pending input buffer
// so the next vector can be accepted while the current one is in flight).
module ff256_ct_seq_ctrl_acc
  import ff256_ct_seq_ctrl_acc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  ff256_ct_seq_ctrl_acc_if.slave bus
);

  state_t           state_r;
  logic [SEL_W-1:0] step_r;
  logic [VEC_W-1:0] x_hold_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             in_hs_s;
  logic             acc_en_s;
  logic             load_en_s;
  logic [SYM_W-1:0] prod_s [0:N_LANES-1];
  logic [SYM_W-1:0] acc_s  [0:N_LANES-1];
  logic [VEC_W-1:0] y_s;

`ifdef FF256_CT_SEQ_DBUF_EN
  logic             pend_full_r;
  logic [VEC_W-1:0] pend_buf_r;
`endif

  assign in_hs_s   = bus.in_valid & in_ready_r;
  assign acc_en_s  = (state_r == ST_COMPUTE);
  assign load_en_s = acc_en_s & (step_r == STEP_ZERO);

  // Lane i reads symbol (i + step) mod 8; 3-bit add wraps 7->0 by itself.
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign bus.selector[g] = SEL_W'(g) + step_r;
    assign prod_s[g]       = bus.prod[g];
  end

  ff256_ct_seq_xor_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (load_en_s),
    .acc_en  (acc_en_s),
    .prod    (prod_s),
    .acc     (acc_s)
  );

  // Pack the lane accumulators into the result vector, lane i at byte i.
  always_comb begin
    y_s = {VEC_W{1'b0}};
    for (int i = 0; i < N_LANES; i++) y_s[SYM_W*i +: SYM_W] = acc_s[i];
  end

  // Control FSM: IDLE accepts, COMPUTE steps 0..7, DONE holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      step_r      <= STEP_ZERO;
      x_hold_r    <= {VEC_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef FF256_CT_SEQ_DBUF_EN
      pend_full_r <= 1'b0;
      pend_buf_r  <= {VEC_W{1'b0}};
`endif
    end else begin
`ifdef FF256_CT_SEQ_DBUF_EN
      // Ready tracks buffer occupancy in every state; cases below override.
      in_ready_r <= ~pend_full_r;
`endif
      case (state_r)
        ST_IDLE: begin
          if (in_hs_s) begin
            x_hold_r <= bus.x_in;
            step_r   <= STEP_ZERO;
            state_r  <= ST_COMPUTE;
            busy_r   <= 1'b1;
`ifndef FF256_CT_SEQ_DBUF_EN
            in_ready_r <= 1'b0;
`endif
          end else begin
`ifndef FF256_CT_SEQ_DBUF_EN
            in_ready_r <= 1'b1;
`endif
          end
        end

        ST_COMPUTE: begin
          step_r <= step_r + STEP_ONE;
          if (step_r == STEP_LAST) begin
            step_r      <= STEP_ZERO;
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end
`ifdef FF256_CT_SEQ_DBUF_EN
          if (in_hs_s) begin
            pend_buf_r  <= bus.x_in;
            pend_full_r <= 1'b1;
            in_ready_r  <= 1'b0;
          end
`endif
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
`ifdef FF256_CT_SEQ_DBUF_EN
            if (pend_full_r) begin
              x_hold_r    <= pend_buf_r;
              pend_full_r <= 1'b0;
              in_ready_r  <= 1'b1;
              step_r      <= STEP_ZERO;
              state_r     <= ST_COMPUTE;
            end else if (in_hs_s) begin
              x_hold_r <= bus.x_in;
              step_r   <= STEP_ZERO;
              state_r  <= ST_COMPUTE;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
`else
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
`endif
          end else begin
`ifdef FF256_CT_SEQ_DBUF_EN
            if (in_hs_s) begin
              pend_buf_r  <= bus.x_in;
              pend_full_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end
`endif
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          step_r      <= STEP_ZERO;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.x_hold    = x_hold_r;
  assign bus.step      = step_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.y_out     = y_s;

endmodule
